paddle_buttons: RTL and testbench

PADDLE_BUTTONS -- requirements
Module: paddle_buttons

---
 rtl/paddle_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 124 ++++++++++++
 rtl/paddle_buttons.sv | 88 ++++++++
 tb/tb_paddle_buttons.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle button front end: per-channel FSM state
// encoding, channel index constants and default timing parameters.
package paddle_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_CHK   = 3'd4
    } btn_state_e;

    localparam int NUM_CH = 4;
    localparam int LU     = 0;
    localparam int LD     = 1;
    localparam int RU     = 2;
    localparam int RD     = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 6250000;
    localparam int DEF_REPEAT_PERIOD   = 416667;
    localparam int DEF_CNT_W           = 23;

endpackage

// File: rtl/btn_debounce.sv
// Single button channel: 2-flop synchronizer, debounce/hold FSM and counter.
// evt_o is a one-clock event raised on the transition that accepts a press
// (and, when PADDLE_AUTO_REPEAT_EN is defined, on each auto-repeat tick).
module btn_debounce
    import paddle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`ifdef PADDLE_AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic evt_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef PADDLE_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic             sync1_q;
    logic             sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and event decode; every compare is an equality test.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_o   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    evt_o   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
`ifdef PADDLE_AUTO_REPEAT_EN
                else if (cnt_q == DLY_LAST) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    evt_o   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef PADDLE_AUTO_REPEAT_EN
            REPEAT: begin
                if (!sync2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    evt_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            REL_CHK: begin
                if (sync2_q) begin
                    // Bounce during release: back to held, repeat delay restarts.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/paddle_buttons.sv
// Paddle button front end: four debounced channels, same-paddle conflict
// filter, per-channel pending flags and a fixed-priority one-hot arbiter.
// Outputs are one-clock pulses straight from flops.
// Build option: define PADDLE_AUTO_REPEAT_EN to enable hold-to-repeat.
module paddle_buttons
    import paddle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic       left_up,
    output logic       left_down,
    output logic       right_up,
    output logic       right_down
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 8 || REPEAT_DELAY >= (1 << CNT_W)) begin : g_bad_params
        $error("paddle_buttons: unsupported timing parameters");
    end

    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] evt_ok;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] out_q, out_d;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef PADDLE_AUTO_REPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn_raw[ch]),
            .evt_o (evt[ch])
        );
    end

    // Opposite directions of one paddle in the same clock cancel each other.
    always_comb begin
        evt_ok     = '0;
        evt_ok[LU] = evt[LU] & ~evt[LD];
        evt_ok[LD] = evt[LD] & ~evt[LU];
        evt_ok[RU] = evt[RU] & ~evt[RD];
        evt_ok[RD] = evt[RD] & ~evt[RU];
    end

    // Fixed-priority grant from pending flags; an event on an already pending
    // channel (including the clock it is granted) merges into that flag.
    always_comb begin
        out_d = '0;
        if (pend_q[LU]) begin
            out_d[LU] = 1'b1;
        end else if (pend_q[LD]) begin
            out_d[LD] = 1'b1;
        end else if (pend_q[RU]) begin
            out_d[RU] = 1'b1;
        end else if (pend_q[RD]) begin
            out_d[RD] = 1'b1;
        end
        pend_d = (pend_q & ~out_d) | (~pend_q & evt_ok);
    end

    // Pending flags and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            out_q  <= '0;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

    assign left_up    = out_q[LU];
    assign left_down  = out_q[LD];
    assign right_up   = out_q[RU];
    assign right_down = out_q[RD];

endmodule

// File: tb/tb_paddle_buttons.sv
// Bench for paddle_buttons with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=10. Expected output pulses are queued with their absolute
// clock number when stimulus is driven, and every clock the outputs are
// compared with the queue head (all-zero when nothing is due).
module tb_paddle_buttons;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 10;
    localparam int CW   = 8;
    localparam int LAT  = DEB + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       left_up, left_down, right_up, right_down;
    logic [3:0] outs;

    assign outs = {right_down, right_up, left_down, left_up};

    paddle_buttons #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER),
        .CNT_W           (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .left_up    (left_up),
        .left_down  (left_down),
        .right_up   (right_up),
        .right_down (right_down)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] outs;
    } exp_t;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic push(input int c, input logic [3:0] o);
        exp_t e;
        e.cyc  = c;
        e.outs = o;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and compare outputs with the queue.
    task automatic tick();
        exp_t       e;
        logic [3:0] want;
        @(negedge clk);
        want = 4'b0000;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e    = sb.pop_front();
            want = e.outs;
        end
        check($sformatf("outs@%0d", cyc), outs, want);
    endtask

    // Raw press sampled at edges E..E+hold-1, then a quiet gap.
    task automatic run_vec(input vec_t v);
        int e;
        e = cyc + 1;
        btn_raw = v.btn;
        if (v.exp_a != 4'b0000) push(e + LAT, v.exp_a);
        if (v.exp_b != 4'b0000) push(e + LAT + 1, v.exp_b);
        repeat (v.hold) tick();
        btn_raw = 4'b0000;
        repeat (12) tick();
    endtask

    initial begin
        int e;

        tbl[0]  = '{4'b0001, 12, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b0010, 12, 4'b0010, 4'b0000};
        tbl[2]  = '{4'b0100, 12, 4'b0100, 4'b0000};
        tbl[3]  = '{4'b1000, 12, 4'b1000, 4'b0000};
        tbl[4]  = '{4'b0101, 12, 4'b0001, 4'b0100};
        tbl[5]  = '{4'b0011, 12, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1100, 12, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1010, 12, 4'b0010, 4'b1000};
        tbl[8]  = '{4'b1111, 12, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0111, 12, 4'b0100, 4'b0000};
        tbl[10] = '{4'b0110, 12, 4'b0010, 4'b0100};
        tbl[11] = '{4'b1001, 12, 4'b0001, 4'b1000};
        tbl[12] = '{4'b0001,  4, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0001,  5, 4'b0001, 4'b0000};
        tbl[14] = '{4'b1101, 12, 4'b0001, 4'b0000};

        // Reset state.
        rst_n = 1'b0;
        #1;
        check("reset_state", outs, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 15; i++) begin
            run_vec(tbl[i]);
        end

        // Long hold: first pulse, then auto-repeat cadence.
        e = cyc + 1;
        btn_raw = 4'b0001;
        push(e + LAT, 4'b0001);
`ifdef PADDLE_AUTO_REPEAT_EN
        for (int k = 0; k < 4; k++) push(e + LAT + RDLY + k * RPER, 4'b0001);
`endif
        repeat (60) tick();
        btn_raw = 4'b0000;
        repeat (14) tick();

        // Bouncy short presses never get accepted.
        for (int k = 0; k < 30; k++) begin
            btn_raw = (k % 3 == 2) ? 4'b0000 : 4'b0010;
            tick();
        end
        btn_raw = 4'b0000;
        repeat (10) tick();

        // Two-clock release while held: no extra pulse, repeat delay restarts.
        e = cyc + 1;
        btn_raw = 4'b0001;
        push(e + LAT, 4'b0001);
`ifdef PADDLE_AUTO_REPEAT_EN
        push(e + 14 + RDLY + 1, 4'b0001);
        push(e + 14 + RDLY + 1 + RPER, 4'b0001);
        push(e + 14 + RDLY + 1 + 2 * RPER, 4'b0001);
`endif
        repeat (10) tick();
        btn_raw = 4'b0000;
        repeat (2) tick();
        btn_raw = 4'b0001;
        repeat (48) tick();
        btn_raw = 4'b0000;
        repeat (14) tick();

        // Reset mid-press: press lost, full debounce again after release.
        e = cyc + 1;
        btn_raw = 4'b0001;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_press", outs, 4'b0000);
        repeat (2) tick();
        rst_n = 1'b1;
        push(e + 7 + LAT, 4'b0001);
        repeat (23) tick();
        btn_raw = 4'b0000;
        repeat (12) tick();

        // Reset while a pulse is high and another channel is pending.
        e = cyc + 1;
        btn_raw = 4'b0101;
        push(e + LAT, 4'b0001);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", outs, 4'b0000);
        btn_raw = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();

        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: got %0d pending entries want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
